dac_spi_master_q: RTL and testbench



---
 rtl/dac_spi_pkg.sv | 15 +
 rtl/dac_spi_master_q_fifo.sv | 42 ++++
 rtl/dac_spi_master_q.sv | 167 ++++++++++++++++
 tb/tb_dac_spi_master_q.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_spi_pkg.sv
// Shared types and sizing helpers for the queued DAC SPI master.
package dac_spi_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  // One counter width covers the divider, bit index and gap timer.
  function automatic int cnt_width(input int clk_div, input int sync_gap, input int frame_width);
    int m;
    m = clk_div;
    if (sync_gap > m) m = sync_gap;
    if (frame_width > m) m = frame_width;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/dac_spi_master_q_fifo.sv
// Command FIFO; pointers carry one extra wrap bit so full and empty are distinguishable.
module dac_spi_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr_reg[AW-1:0]];
  assign level = wr_ptr_reg - rd_ptr_reg;
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/dac_spi_master_q.sv
// Queued write-only SPI master: frames are popped from a FIFO and streamed to the DAC
// with a fixed SYNC gap between them.
module dac_spi_master_q
  import dac_spi_pkg::*;
#(
  parameter int FRAME_WIDTH = 24,
  parameter int CLK_DIV     = 2,
  parameter int SYNC_GAP    = 5,
  parameter int FIFO_DEPTH  = 4,
  parameter int SCLK_IDLE   = 1,
  parameter int MSB_FIRST   = 1
) (
  input  logic                           clk_i,
  input  logic                           arst_ni,
  input  logic [FRAME_WIDTH-1:0]         data_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  output logic                           mosi_o,
  output logic                           sclk_o,
  output logic                           sync_no,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level_o
);

  localparam int   CW       = cnt_width(CLK_DIV, SYNC_GAP, FRAME_WIDTH);
  localparam logic IDLE_LVL = 1'(SCLK_IDLE);

  if (CLK_DIV < 1 || SYNC_GAP < 1 || FRAME_WIDTH < 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $fatal(1, "dac_spi_master_q: illegal parameter combination");
  end

  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FRAME_WIDTH-1:0] fifo_rdata;

  assign ready_o   = !fifo_full;
  assign fifo_push = valid_i && !fifo_full;

  dac_spi_fifo #(.WIDTH(FRAME_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wdata   (data_i),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level_o)
  );

  function automatic logic head(input logic [FRAME_WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[FRAME_WIDTH-1] : w[0];
  endfunction

  function automatic logic [FRAME_WIDTH-1:0] advance(input logic [FRAME_WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[FRAME_WIDTH-2:0], 1'b0} : {1'b0, w[FRAME_WIDTH-1:1]};
  endfunction

  state_t                 state_reg, state_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic [CW-1:0]          bit_reg, bit_next;
  logic                   phase_reg, phase_next;
  logic [FRAME_WIDTH-1:0] shreg_reg, shreg_next;
  logic                   sclk_reg, sclk_next;
  logic                   sync_reg, sync_next;
  logic                   mosi_reg, mosi_next;
  logic                   busy_reg, busy_next;
  logic                   done_reg, done_next;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      phase_reg <= 1'b0;
      shreg_reg <= '0;
      sclk_reg  <= IDLE_LVL;
      sync_reg  <= 1'b1;
      mosi_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      phase_reg <= phase_next;
      shreg_reg <= shreg_next;
      sclk_reg  <= sclk_next;
      sync_reg  <= sync_next;
      mosi_reg  <= mosi_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // phase_reg: 0 = first half-bit (SCLK idle), 1 = second half-bit (SCLK leading level)
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    phase_next = phase_reg;
    shreg_next = shreg_reg;
    sclk_next  = sclk_reg;
    sync_next  = sync_reg;
    mosi_next  = mosi_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    fifo_pop   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shreg_next = fifo_rdata;
          mosi_next  = head(fifo_rdata);
          sync_next  = 1'b0;
          busy_next  = 1'b1;
          sclk_next  = IDLE_LVL;
          cnt_next   = '0;
          bit_next   = '0;
          phase_next = 1'b0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_reg == CW'(CLK_DIV - 1)) begin
          cnt_next = '0;
          if (!phase_reg) begin
            phase_next = 1'b1;
            sclk_next  = ~IDLE_LVL;
          end else begin
            phase_next = 1'b0;
            sclk_next  = IDLE_LVL;
            if (bit_reg == CW'(FRAME_WIDTH - 1)) begin
              sync_next  = 1'b1;
              done_next  = 1'b1;
              state_next = GAP;
            end else begin
              bit_next   = bit_reg + 1'b1;
              shreg_next = advance(shreg_reg);
              mosi_next  = head(advance(shreg_reg));
            end
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      GAP: begin
        if (cnt_reg == CW'(SYNC_GAP - 1)) begin
          cnt_next   = '0;
          busy_next  = !fifo_empty;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign sclk_o  = sclk_reg;
  assign sync_no = sync_reg;
  assign mosi_o  = mosi_reg;
  assign busy_o  = busy_reg;
  assign done_o  = done_reg;

endmodule

// File: tb/tb_dac_spi_master_q.sv
// Randomized bench: an MSB-first and an LSB-first master share one push stream and are
// checked against a slave model and a FIFO occupancy model.
module tb_dac_spi_master_q;

  localparam int FW        = 8;
  localparam int CD        = 2;
  localparam int SG        = 5;
  localparam int DEPTH     = 4;
  localparam int LW        = $clog2(DEPTH + 1);
  localparam int FRAME_CYC = 2 * CD * FW;
  localparam int PERIOD    = FRAME_CYC + SG + 1;

  logic          clk_i   = 1'b0;
  logic          arst_ni = 1'b0;
  logic          valid_i = 1'b0;
  logic [FW-1:0] data_i  = '0;
  logic          ready [2];
  logic          mosi  [2];
  logic          sclk  [2];
  logic          sync_n[2];
  logic          busy  [2];
  logic          done  [2];
  logic [LW-1:0] level [2];

  always #5 clk_i = ~clk_i;

  dac_spi_master_q #(.FRAME_WIDTH(FW), .CLK_DIV(CD), .SYNC_GAP(SG), .FIFO_DEPTH(DEPTH),
                     .SCLK_IDLE(1), .MSB_FIRST(1)) u_msb (
    .clk_i(clk_i), .arst_ni(arst_ni), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready[0]), .mosi_o(mosi[0]), .sclk_o(sclk[0]), .sync_no(sync_n[0]),
    .busy_o(busy[0]), .done_o(done[0]), .level_o(level[0]));

  dac_spi_master_q #(.FRAME_WIDTH(FW), .CLK_DIV(CD), .SYNC_GAP(SG), .FIFO_DEPTH(DEPTH),
                     .SCLK_IDLE(1), .MSB_FIRST(0)) u_lsb (
    .clk_i(clk_i), .arst_ni(arst_ni), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready[1]), .mosi_o(mosi[1]), .sclk_o(sclk[1]), .sync_no(sync_n[1]),
    .busy_o(busy[1]), .done_o(done[1]), .level_o(level[1]));

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted word in order; pops/completions per master.
  logic [FW-1:0] exp_arr[$];
  int            n_push = 0;
  int            n_pop [2];
  int            n_done[2];
  bit            stall_seen;

  // Slave-side monitor state
  bit            prev_sync[2], prev_sclk[2], b2b[2], gap_busy_ok[2], seen_frame[2];
  int            low_cnt[2], high_cnt[2], nbits[2], cur_idx[2], last_start[2];
  int            cyc = 0;
  logic [FW-1:0] rxw[2];

  always @(negedge clk_i) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!arst_ni) begin
        prev_sync[i] = 1'b1; prev_sclk[i] = 1'b1; b2b[i] = 1'b0; seen_frame[i] = 1'b0;
        gap_busy_ok[i] = 1'b1; low_cnt[i] = 0; high_cnt[i] = 0; nbits[i] = 0;
        rxw[i] = '0; n_pop[i] = n_push; n_done[i] = n_push;
      end else begin
        bit            start_f, fin_f;
        int            pend;
        logic [31:0]   expw;
        start_f = prev_sync[i] && !sync_n[i];
        fin_f   = !prev_sync[i] && sync_n[i];
        if (start_f) begin
          if (b2b[i]) begin
            check($sformatf("d%0d_gap_len", i), high_cnt[i], SG + 1);
            check($sformatf("d%0d_period", i), cyc - last_start[i], PERIOD);
            check($sformatf("d%0d_busy_across", i), gap_busy_ok[i], 1);
          end else if (seen_frame[i]) begin
            check($sformatf("d%0d_gap_min", i), high_cnt[i] >= SG + 1, 1);
          end
          cur_idx[i] = n_pop[i];
          n_pop[i]++;
          low_cnt[i] = 0; nbits[i] = 0; last_start[i] = cyc; seen_frame[i] = 1'b1;
        end
        pend = n_push - n_pop[i];
        check($sformatf("d%0d_done", i), done[i], fin_f);
        check($sformatf("d%0d_level", i), level[i], pend);
        check($sformatf("d%0d_ready", i), ready[i], pend < DEPTH);
        if (fin_f) begin
          expw = (cur_idx[i] < exp_arr.size()) ? 32'(exp_arr[cur_idx[i]]) : 32'hFFFF_FFFF;
          check($sformatf("d%0d_frame_len", i), low_cnt[i], FRAME_CYC);
          check($sformatf("d%0d_nbits", i), nbits[i], FW);
          check($sformatf("d%0d_data", i), rxw[i], expw);
          n_done[i]++;
          b2b[i] = (pend > 0);
          high_cnt[i] = 0;
          gap_busy_ok[i] = 1'b1;
        end
        if (!sync_n[i]) begin
          low_cnt[i]++;
          check($sformatf("d%0d_busy_frame", i), busy[i], 1);
          if (prev_sclk[i] && !sclk[i]) begin
            rxw[i] = (i == 0) ? {rxw[i][FW-2:0], mosi[i]} : {mosi[i], rxw[i][FW-1:1]};
            nbits[i]++;
          end
        end else begin
          high_cnt[i]++;
          if (!busy[i]) gap_busy_ok[i] = 1'b0;
          check($sformatf("d%0d_sclk_idle", i), sclk[i], 1);
          if ((high_cnt[i] >= SG + 1 || !seen_frame[i]) && pend == 0)
            check($sformatf("d%0d_busy_idle", i), busy[i], 0);
        end
        prev_sync[i] = sync_n[i];
        prev_sclk[i] = sclk[i];
      end
    end
  end

  task automatic check_idle(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s%0d_sclk", tag, i), sclk[i], 1);
      check($sformatf("%s%0d_sync", tag, i), sync_n[i], 1);
      check($sformatf("%s%0d_mosi", tag, i), mosi[i], 0);
      check($sformatf("%s%0d_busy", tag, i), busy[i], 0);
      check($sformatf("%s%0d_done", tag, i), done[i], 0);
      check($sformatf("%s%0d_ready", tag, i), ready[i], 1);
      check($sformatf("%s%0d_level", tag, i), level[i], 0);
    end
  endtask

  task automatic push_word(input logic [FW-1:0] w);
    int t = 0;
    @(negedge clk_i);
    valid_i = 1'b1;
    data_i  = w;
    while (!ready[0] && t < 500) begin
      stall_seen = 1'b1;
      @(negedge clk_i);
      t++;
    end
    check("push_timeout", t < 500, 1);
    @(posedge clk_i);
    exp_arr.push_back(w);
    n_push++;
  endtask

  task automatic idle_in();
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((n_done[0] != n_push || n_done[1] != n_push || busy[0] || busy[1]) && t < 3000) begin
      @(negedge clk_i);
      t++;
    end
    check("drain_timeout", t < 3000, 1);
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] stream_w [6];
    int t;
    stream_w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    // Reset, then 50 idle cycles with no traffic.
    repeat (3) @(negedge clk_i);
    #2 arst_ni = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk_i);
      #1 check_idle("rst_idle");
    end

    // Single frames, including the bit-order probe 0x01.
    push_word(8'hAA);
    idle_in();
    wait_drain();
    push_word(8'h01);
    idle_in();
    wait_drain();

    // Streaming: six words back to back into a four-deep FIFO must stall once.
    stall_seen = 1'b0;
    for (int k = 0; k < 6; k++) push_word(stream_w[k]);
    idle_in();
    check("full_stall", stall_seen, 1);
    wait_drain();

    // Push in the very cycle the first word is popped: occupancy stays at one.
    push_word(8'hC3);
    push_word(8'h5A);
    @(negedge clk_i);
    valid_i = 1'b0;
    check("pushpop_level0", level[0], 1);
    check("pushpop_level1", level[1], 1);
    wait_drain();

    // Reset in the middle of a frame, then a clean frame afterwards.
    push_word(8'h96);
    push_word(8'h69);
    idle_in();
    t = 0;
    while (nbits[0] < 3 && t < 500) begin
      @(negedge clk_i);
      t++;
    end
    check("midrst_wait", t < 500, 1);
    #2 arst_ni = 1'b0;
    #1 check_idle("midrst");
    repeat (2) @(negedge clk_i);
    #2 arst_ni = 1'b1;
    push_word(8'h3C);
    idle_in();
    wait_drain();

    // Random traffic: a dense burst phase followed by a sparse phase.
    for (int c = 0; c < 600; c++) begin
      bit go;
      @(negedge clk_i);
      valid_i = ($urandom_range(0, 99) < ((c < 300) ? 40 : 3));
      data_i  = FW'($urandom);
      go      = valid_i && ready[0];
      @(posedge clk_i);
      if (go) begin
        exp_arr.push_back(data_i);
        n_push++;
      end
    end
    idle_in();
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
